// File: rtl/fix14_dot_seq.sv
// fix14_dot_seq: streaming dot-product sequencer placed in front of a fix14
// 16x16 signed multiplier DSP wrapper.
//
// (x, w) pairs arrive on a valid/ready stream and are registered onto the
// multiplier's A/B inputs. The fix14 product that comes back is accumulated
// until the pair marked in_last has been multiplied. One fix14 result per
// vector is then presented on a valid/ready output.
//
// Ports
//   sys_clk    in   1      system clock, rising edge
//   sys_rst    in   1      synchronous reset, active-high
//   in_valid   in   1      input pair valid
//   in_ready   out  1      sequencer can accept a pair
//   in_x       in   D_W    sample, fix14 signed
//   in_w       in   D_W    weight, fix14 signed
//   in_last    in   1      final pair of the vector
//   mul_a      out  D_W    to DSP A, registered
//   mul_b      out  D_W    to DSP B, registered
//   mul_p      in   D_W    fix14 product from DSP (its O[29:14])
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_data   out  D_W    fix14 dot product
//   out_count  out  CNT_W  number of pairs in the vector (saturating)
//   out_ovf    out  1      result exceeded fix14 range
//
// Build option
//   FIX14_DOT_SAT_EN  When this macro is defined, out_data is clamped to
//                     0x8000..0x7FFF and out_ovf flags a clamp. When it is
//                     undefined, out_data is the low D_W bits of the sum
//                     and out_ovf is always 0.
//
// State | Meaning
// ------+--------------------------------------------------------------
// ACC   | accepting pairs; in_ready=1
// DRAIN | last pair taken; waiting for its product to leave the pipeline
// HOLD  | result presented; out_valid=1 until the output handshake

module fix14_dot_seq #(
    parameter int D_W     = 16,
    parameter int ACC_W   = 24,
    parameter int MUL_LAT = 0,
    parameter int CNT_W   = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D_W-1:0]   in_x,
    input  logic [D_W-1:0]   in_w,
    input  logic             in_last,
    output logic [D_W-1:0]   mul_a,
    output logic [D_W-1:0]   mul_b,
    input  logic [D_W-1:0]   mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D_W-1:0]   out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    // One stage for the A/B register, plus the DSP's own pipeline depth.
    localparam int TOK_D = MUL_LAT + 1;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             accept;
    logic             hs_out;
    logic [TOK_D-1:0] tok_v;
    logic [TOK_D-1:0] tok_l;
    logic             exit_v;
    logic             exit_l;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] count;
    logic [D_W-1:0]   res_data;
    logic             res_ovf;

    assign accept  = in_valid & in_ready;
    assign hs_out  = out_valid & out_ready;
    assign exit_v  = tok_v[TOK_D-1];
    assign exit_l  = tok_l[TOK_D-1];
    assign p_ext   = {{(ACC_W-D_W){mul_p[D_W-1]}}, mul_p};
    assign acc_sum = acc + p_ext;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (exit_v && exit_l) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

`ifdef FIX14_DOT_SAT_EN
    // The sum fits in D_W bits when every bit above the D_W sign bit
    // matches that sign bit.
    logic sum_fits;

    assign sum_fits = (acc_sum[ACC_W-1:D_W-1] == {(ACC_W-D_W+1){acc_sum[D_W-1]}});

    always_comb begin
        res_data = acc_sum[D_W-1:0];
        res_ovf  = 1'b0;
        if (!sum_fits) begin
            res_ovf  = 1'b1;
            res_data = acc_sum[ACC_W-1] ? {1'b1, {(D_W-1){1'b0}}}
                                        : {1'b0, {(D_W-1){1'b1}}};
        end
    end
`else
    assign res_data = acc_sum[D_W-1:0];
    assign res_ovf  = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mul_a     <= '0;
            mul_b     <= '0;
            tok_v     <= '0;
            tok_l     <= '0;
            acc       <= '0;
            count     <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (accept) begin
                mul_a <= in_x;
                mul_b <= in_w;
            end

            // Each token travels alongside its product through the DSP
            // pipeline. The truncating cast turns this into a plain shift
            // for any depth, including a depth of one.
            tok_v <= TOK_D'({tok_v, accept});
            tok_l <= TOK_D'({tok_l, accept & in_last});

            // The handshake happens only in HOLD. No pairs are accepted and
            // no tokens are in flight then, so clearing here cannot lose data.
            if (hs_out) begin
                acc   <= '0;
                count <= '0;
            end else begin
                if (accept && (count != {CNT_W{1'b1}})) begin
                    count <= count + 1'b1;
                end
                if (exit_v) begin
                    acc <= acc_sum;
                end
            end

            // The last pair was counted when it was accepted, at least one
            // cycle earlier, so count is already final here.
            if (exit_v && exit_l) begin
                out_data  <= res_data;
                out_ovf   <= res_ovf;
                out_count <= count;
            end
        end
    end

endmodule

// File: doc/fix14_dot_seq.md
Name: fix14_dot_seq

Overview:
- Streaming dot-product sequencer that sits directly upstream of the fix14 16x16 signed multiplier DSP wrapper.
- Accepts (x, w) sample pairs on a valid/ready stream and drives them registered into the multiplier's A/B inputs.
- Takes the multiplier's fix14 product back, accumulates it over a vector terminated by in_last, and presents one fix14 result per vector on a valid/ready output.
- Serves FIR taps, matrix rows and state-machine control-law evaluation.

Parameters:
- D_W, 16, data width; fixed-point format is fix14 (Q2.14: 0x4000 = 1.0, range -2.0 .. +2-2^-14)
- ACC_W, 24, accumulator width; must be >= D_W + ceil(log2(max vector length))
- MUL_LAT, 0, cycles from mul_a/mul_b change to valid mul_p (0 = unregistered DSP, 1 or 2 = pipelined DSP)
- CNT_W, 8, element counter width

Ports:
- sys_clk  in  1  system clock, rising edge
- sys_rst  in  1  synchronous reset, active-high
- in_valid  in  1  input pair valid
- in_ready  out  1  sequencer can accept a pair
- in_x  in  D_W  sample, fix14 signed
- in_w  in  D_W  weight, fix14 signed
- in_last  in  1  final pair of the vector
- mul_a  out  D_W  to DSP A, registered
- mul_b  out  D_W  to DSP B, registered
- mul_p  in  D_W  fix14 product from DSP (its O[29:14])
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  D_W  fix14 dot product
- out_count  out  CNT_W  number of pairs in the vector
- out_ovf  out  1  result exceeded fix14 range

Behaviour:
- Reset (sys_rst high at a clock edge):
  - state=ACC; in_ready=1 in the following cycle.
  - mul_a, mul_b, out_data and out_count reset to 0; out_valid and out_ovf reset to 0.
  - Accumulator, element counter and pipeline valid/last shift register are cleared.
  - Products still in flight are discarded.
- States and transitions:
  - ACC: in_ready=1.
    - Pair accepted on in_valid&in_ready: mul_a<=in_x, mul_b<=in_w, element count increments (saturating at 2^CNT_W-1), and a token {valid,last} enters a shift register of depth 1+MUL_LAT.
    - in_last accepted -> DRAIN.
  - DRAIN: in_ready=0; waits for the last token.
  - HOLD: out_valid=1; out_data, out_count and out_ovf are stable.
    - out_valid&out_ready -> ACC; accumulator and counter are cleared in the same edge.
    - No combinational path from out_ready to in_ready; in_ready rises the cycle after the handshake.
- Accumulation:
  - When a valid token exits the shift register, acc <= acc + sign_extend(mul_p).
  - The accumulator wraps at ACC_W with no flag.
  - mul_a/mul_b hold their value when no pair is accepted.
- Completion:
  - When the exiting token has last=1, out_data/out_ovf are loaded from the final sum (including that product), out_count is loaded from the element counter, and state -> HOLD.
  - Latency: last pair accepted in cycle t -> out_valid high in cycle t+2+MUL_LAT.
- Boundary cases:
  - A single-pair vector (in_last on the first pair) is legal.
  - in_valid while in_ready=0 is ignored; the source must hold it.
  - Back-to-back vectors: the first pair of vector N+1 is accepted the cycle after vector N's output handshake.
  - Counter saturation does not affect the arithmetic.
  - in_last with in_valid=0 is ignored.

Optional Feature:
- Macro FIX14_DOT_SAT_EN.
- Defined: out_data = clamp(acc, 0x8000, 0x7FFF); out_ovf=1 when clamping occurred.
- Undefined: out_data = acc[D_W-1:0] (two's-complement wrap); out_ovf tied 0; clamp logic is not synthesised.

Test Plan:
- MUL_LAT=0, one pair x=0x4000, w=0x4000, last=1 -> out_valid in cycle t+2, out_data=0x4000, out_count=1, out_ovf=0.
- Vector (0x4000,0x2000),(0x2000,0x2000,last) -> out_data=0x3000 (0.5+0.25), out_count=2; in_ready low from the cycle after last until the handshake.
- Signed check: (0xC000,0x4000,last) -> out_data=0xC000 (-1.0).
- Three pairs (0x7FFF,0x4000) -> sum 0x17FFD:
  - with FIX14_DOT_SAT_EN: out_data=0x7FFF, out_ovf=1;
  - without: out_data=0x7FFD, out_ovf=0.
- Backpressure: out_ready low 5 cycles while out_valid -> out_data/out_count stable and in_ready=0; out_ready high -> in_ready=1 next cycle; next vector result is not contaminated (1 pair 0x4000x0x4000 -> 0x4000).
- Reset mid-vector with MUL_LAT=2, after 2 of 4 pairs:
  - cycle after reset: out_valid=0, in_ready=1; in-flight products are discarded.
  - new vector (0x2000,0x4000,last) -> out_data=0x2000, out_count=1.
